mac_acc_seq: RTL and testbench



---
 rtl/vae_fx_pkg.sv | 24 ++
 rtl/fx_round_sat.sv | 45 ++++
 rtl/mac_acc_seq.sv | 137 +++++++++++++
 tb/tb_mac_acc_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/vae_fx_pkg.sv
// Shared fixed-point definitions for the VAE datapath blocks.
//
// Contents:
//   VAE_DATA_W / VAE_FRAC_W  default word width and fractional bits (Q8.8)
//   FX_ONE, FX_HALF_LSB      1.0 and half an output LSB in the default format
//   FX_MAX_S, FX_MIN_S       largest / smallest signed value in the default format
//   state_e                  shared IDLE/ACC/OUT state encoding for sequencers
package vae_fx_pkg;

  localparam int VAE_DATA_W = 16;
  localparam int VAE_FRAC_W = 8;

  localparam logic [VAE_DATA_W-1:0] FX_ONE      = VAE_DATA_W'(1) << VAE_FRAC_W;
  localparam logic [VAE_DATA_W-1:0] FX_HALF_LSB = VAE_DATA_W'(1) << (VAE_FRAC_W - 1);
  localparam logic [VAE_DATA_W-1:0] FX_MAX_S    = {1'b0, {(VAE_DATA_W-1){1'b1}}};
  localparam logic [VAE_DATA_W-1:0] FX_MIN_S    = {1'b1, {(VAE_DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/fx_round_sat.sv
// Combinational round-half-up and saturation of a wide signed accumulator
// down to a signed OUT_W-bit word.
//
// Ports:
//   acc_i  in   IN_W   signed accumulator, FRAC_W fractional bits below the output LSB
//   res_o  out  OUT_W  rounded value, clamped to the signed OUT_W range
//   ovf_o  out  1      high when res_o was clamped
//
// FRAC_W must be >= 2 and IN_W > OUT_W + FRAC_W.
module fx_round_sat #(
  parameter int IN_W   = 40,
  parameter int OUT_W  = 16,
  parameter int FRAC_W = 8
) (
  input  logic signed [IN_W-1:0]  acc_i,
  output logic        [OUT_W-1:0] res_o,
  output logic                    ovf_o
);

  // One extra bit so adding the rounding constant can never wrap.
  localparam logic signed [IN_W:0] HALF  =
    {{(IN_W+1-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
  localparam logic signed [IN_W:0] MAX_V =
    {{(IN_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] MIN_V =
    {{(IN_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W:0] sum;
  logic signed [IN_W:0] t;

  always_comb begin
    sum   = {acc_i[IN_W-1], acc_i} + HALF;
    t     = sum >>> FRAC_W;
    res_o = t[OUT_W-1:0];
    ovf_o = 1'b0;
    if (t > MAX_V) begin
      res_o = {1'b0, {(OUT_W-1){1'b1}}};
      ovf_o = 1'b1;
    end else if (t < MIN_V) begin
      res_o = {1'b1, {(OUT_W-1){1'b0}}};
      ovf_o = 1'b1;
    end
  end

endmodule

// File: rtl/mac_acc_seq.sv
// Sequential fixed-point multiply-accumulate neuron. Accumulates N_IN
// (data, weight) products plus a bias at full precision, then rounds and
// saturates once to DATA_W bits.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   start, bias          begin a result (sampled in IDLE only), bias captured then
//   in_valid/in_ready    operand pair handshake, d_in/w_in signed operands
//   out_valid/out_ready  result handshake, res/ovf held stable while pending
//   busy                 high whenever not IDLE
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds its payload while valid is high and ready is
// low; ready never depends combinationally on valid.
//
// Build option: define MAC_ACC_RELU_EN to clamp negative results to zero
// after saturation (ovf still reports saturation only).
module mac_acc_seq
  import vae_fx_pkg::*;
#(
  parameter int DATA_W = VAE_DATA_W,
  parameter int FRAC_W = VAE_FRAC_W,
  parameter int N_IN   = 2,
  parameter int ACC_W  = 2*DATA_W + 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] bias,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] d_in,
  input  logic [DATA_W-1:0] w_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] res,
  output logic              ovf,
  output logic              busy
);

  localparam int              CNT_W = $clog2(N_IN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_IN - 1);

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q,   acc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] res_q,   res_d;
  logic              ovf_q,   ovf_d;

  logic signed [2*DATA_W-1:0] prod;
  logic        [ACC_W-1:0]    prod_ext;
  logic        [ACC_W-1:0]    bias_ext;
  logic        [ACC_W-1:0]    acc_sum;
  logic        [DATA_W-1:0]   sat_res;
  logic                       sat_ovf;
  logic        [DATA_W-1:0]   final_res;

  always_comb begin
    prod     = $signed(d_in) * $signed(w_in);
    prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    bias_ext = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias} << FRAC_W;
    acc_sum  = acc_q + prod_ext;
  end

  // Rounding works on the sum including the final product so the result
  // can be registered on the last handshake.
  fx_round_sat #(
    .IN_W   (ACC_W),
    .OUT_W  (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_round_sat (
    .acc_i (acc_sum),
    .res_o (sat_res),
    .ovf_o (sat_ovf)
  );

`ifdef MAC_ACC_RELU_EN
  assign final_res = sat_res[DATA_W-1] ? '0 : sat_res;
`else
  assign final_res = sat_res;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d   = bias_ext;
          count_d = '0;
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        if (in_valid) begin
          acc_d   = acc_sum;
          count_d = count_q + CNT_W'(1);
          if (count_q == LAST) begin
            res_d   = final_res;
            ovf_d   = sat_ovf;
            state_d = ST_OUT;
          end
        end
      end
      ST_OUT: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_OUT);
  assign busy      = (state_q != ST_IDLE);
  assign res       = res_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_mac_acc_seq.sv
// Self-checking bench for mac_acc_seq: directed cases plus randomized
// transactions scored against a plain-arithmetic reference model.
module tb_mac_acc_seq;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  localparam int N_IN   = 2;
  localparam int ACC_W  = 2*DATA_W + 8;

  logic              clk;
  logic              rst;
  logic              start;
  logic [DATA_W-1:0] bias;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] d_in;
  logic [DATA_W-1:0] w_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] res;
  logic              ovf;
  logic              busy;

  mac_acc_seq #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .N_IN   (N_IN),
    .ACC_W  (ACC_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d_in      (d_in),
    .w_in      (w_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .ovf       (ovf),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  logic [DATA_W:0]   exp_q[$];   // {ovf, res}
  logic [DATA_W:0]   mon_exp;
  int                n_vec = 0;
  int                n_err = 0;

  logic [DATA_W-1:0] cur_bias;
  logic [DATA_W-1:0] cur_d[N_IN];
  logic [DATA_W-1:0] cur_w[N_IN];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: exact integer sum of bias*2^FRAC_W and all products, then
  // round half up, clamp, optional ReLU.
  function automatic logic [DATA_W:0] model_result();
    longint s, t, r;
    longint max_v, min_v;
    logic   o;
    max_v = (longint'(1) << (DATA_W - 1)) - 1;
    min_v = -(longint'(1) << (DATA_W - 1));
    s = longint'($signed(cur_bias)) * (longint'(1) << FRAC_W);
    for (int i = 0; i < N_IN; i++)
      s += longint'($signed(cur_d[i])) * longint'($signed(cur_w[i]));
    t = (s + (longint'(1) << (FRAC_W - 1))) >>> FRAC_W;
    o = 1'b0;
    r = t;
    if (t > max_v) begin r = max_v; o = 1'b1; end
    else if (t < min_v) begin r = min_v; o = 1'b1; end
`ifdef MAC_ACC_RELU_EN
    if (r < 0) r = 0;
`endif
    return {o, DATA_W'(r)};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got %0h expected none", {ovf, res});
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", 32'({ovf, res}), 32'(mon_exp));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_cur(input logic [DATA_W-1:0] b,
                         input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] w0,
                         input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] w1);
    cur_bias = b;
    cur_d[0] = d0; cur_w[0] = w0;
    cur_d[1] = d1; cur_w[1] = w1;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (busy) begin
      n_vec++;
      n_err++;
      $display("FAIL idle_timeout: got busy=1 expected busy=0");
    end
  endtask

  task automatic run_txn(input int gap_max, input int bp);
    logic [DATA_W:0] e;
    int gaps;
    wait_idle();
    e = model_result();
    exp_q.push_back(e);
    bias      = cur_bias;
    start     = 1'b1;
    out_ready = (bp == 0);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      gaps = $urandom_range(gap_max, 0);
      repeat (gaps) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      d_in     = cur_d[i];
      w_in     = cur_w[i];
      check("in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("latency_out_valid", 32'(out_valid), 32'd1);
    repeat (bp) begin
      start = 1'b1;
      check("bp_hold", 32'({ovf, res}), 32'(e));
      check("bp_ctrl", 32'({out_valid, in_ready, busy}), 32'b101);
      @(posedge clk); #1;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("consumed", 32'({out_valid, busy}), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; bias = '0; in_valid = 1'b0;
    d_in = '0; w_in = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'({res, ovf, out_valid, in_ready, busy}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 0.5 + 2*1.5 - 1*1 = 2.5
    set_cur(16'h0080, 16'h0200, 16'h0180, 16'hFF00, 16'h0100);
    run_txn(0, 0);
    set_cur(16'h0000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    run_txn(0, 0);
    set_cur(16'h0000, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF);
    run_txn(0, 0);
    set_cur(16'h0000, 16'h0001, 16'h0080, 16'h0000, 16'h0000);
    run_txn(0, 0);
    set_cur(16'h0000, 16'h0001, 16'h007F, 16'h0000, 16'h0000);
    run_txn(0, 0);
    set_cur(16'h0080, 16'h0200, 16'h0180, 16'hFF00, 16'h0100);
    run_txn(0, 5);
    set_cur(16'hFF00, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    run_txn(0, 0);

    // Reset after the first pair: everything clears at once, nothing emitted.
    set_cur(16'h7000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    run_txn(0, 0);
    wait_idle();
    bias  = 16'h0080;
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b1; d_in = 16'h0200; w_in = 16'h0180;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("reset_mid", 32'({res, ovf, out_valid, in_ready, busy}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    set_cur(16'h0080, 16'h0200, 16'h0180, 16'hFF00, 16'h0100);
    run_txn(0, 0);

    // Randomized transactions with input gaps and output backpressure.
    for (int n = 0; n < 40; n++) begin
      if (n % 2 == 0) begin
        set_cur(DATA_W'($urandom), DATA_W'($urandom), DATA_W'($urandom),
                DATA_W'($urandom), DATA_W'($urandom));
      end else begin
        set_cur(DATA_W'($urandom_range(1023, 0) - 512),
                DATA_W'($urandom_range(1023, 0) - 512),
                DATA_W'($urandom_range(1023, 0) - 512),
                DATA_W'($urandom_range(1023, 0) - 512),
                DATA_W'($urandom_range(1023, 0) - 512));
      end
      run_txn(2, $urandom_range(3, 0));
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
